// File: rtl/mgr_mem_ctrl.sv
// AHB-Lite burst manager: turns read/write burst commands into
// INCR/SINGLE AHB transfers with BUSY stalls and 2-cycle error handling.
module mgr_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [3:0]        cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ACTIVE,
    S_DRAIN,
    S_ERROR
  } state_t;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  state_t state, state_n;

  logic              c_write;
  logic [ADDR_W-1:0] c_addr;
  logic [2:0]        c_size;
  logic [3:0]        c_len;
  logic [3:0]        left;
  logic              dphase;
  logic              dlast;

  logic              bad;
  logic              in_bus;
  logic              e_hit;
  logic              a_cmp;
  logic              d_cmp;
  logic              iss;
  logic              first;
  logic              bsy;
  logic              idl;
  logic [ADDR_W-1:0] nxt;
  logic [ADDR_W-1:0] iss_addr;
  logic [1:0]        iss_trans;

  assign bad = (c_size > 3'd2)
             || (c_size == 3'd1 && c_addr[0])
             || (c_size == 3'd2 && c_addr[1:0] != 2'b00);

  assign nxt    = haddr + (ADDR_W'(1) << c_size);
  assign in_bus = (state == S_ACTIVE) || (state == S_DRAIN);
  assign e_hit  = in_bus && dphase && hresp;
  assign a_cmp  = (state == S_ACTIVE) && htrans[1] && hready && !e_hit;
  assign d_cmp  = in_bus && dphase && hready && !hresp;

  assign cmd_ready = (state == S_IDLE);
  assign wr_ready  = a_cmp && c_write;

  // BUSY already holds the stalled beat's address
  assign iss_addr  = first ? c_addr :
                     (htrans == T_BUSY) ? haddr : nxt;
  assign iss_trans = (first || iss_addr[9:0] == 10'd0) ? T_NSEQ : T_SEQ;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // wr_valid sampled when a write beat's address completes also
  // decides whether the following beat may go out or must BUSY
  always_comb begin
    state_n = state;
    iss     = 1'b0;
    first   = 1'b0;
    bsy     = 1'b0;
    idl     = 1'b0;
    case (state)
      S_IDLE:  if (cmd_valid) state_n = S_CHECK;
      S_CHECK: state_n = bad ? S_IDLE : S_ACTIVE;
      S_ACTIVE: begin
        if (e_hit) begin
          idl     = 1'b1;
          state_n = hready ? S_IDLE : S_ERROR;
        end else if (hready) begin
          unique case (1'b1)
            htrans == T_IDLE: begin
              iss   = !c_write || wr_valid;
              first = !c_write || wr_valid;
            end
            htrans == T_BUSY: iss = wr_valid;
            default: begin
              if (left == 4'd0) begin
                idl     = 1'b1;
                state_n = S_DRAIN;
              end else if (c_write && !wr_valid) begin
                bsy = 1'b1;
              end else begin
                iss = 1'b1;
              end
            end
          endcase
        end
      end
      S_DRAIN: begin
        if (e_hit)               state_n = hready ? S_IDLE : S_ERROR;
        else if (d_cmp && dlast) state_n = S_IDLE;
      end
      S_ERROR: if (hready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_write  <= 1'b0;
      c_addr   <= '0;
      c_size   <= '0;
      c_len    <= '0;
      left     <= '0;
      dphase   <= 1'b0;
      dlast    <= 1'b0;
      haddr    <= '0;
      htrans   <= T_IDLE;
      hwrite   <= 1'b0;
      hsize    <= '0;
      hburst   <= '0;
      hwdata   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      if (state == S_IDLE && cmd_valid) begin
        c_write <= cmd_write;
        c_addr  <= cmd_addr;
        c_size  <= cmd_size;
        c_len   <= cmd_len;
      end
      if (state == S_CHECK && bad) err <= 1'b1;
      if (iss) begin
        haddr  <= iss_addr;
        htrans <= iss_trans;
        left   <= first ? c_len : left - 4'd1;
      end
      if (iss && first) begin
        hwrite <= c_write;
        hsize  <= c_size;
        hburst <= (c_len == 4'd0) ? 3'b000 : 3'b001;
      end
      if (bsy) begin
        haddr  <= nxt;
        htrans <= T_BUSY;
      end
      if (idl) htrans <= T_IDLE;
      if (a_cmp) begin
        dphase <= 1'b1;
        dlast  <= (left == 4'd0);
        if (c_write) hwdata <= wr_data;
      end else if (e_hit || (dphase && hready)) begin
        dphase <= 1'b0;
      end
      if (d_cmp && !c_write) begin
        rd_valid <= 1'b1;
        rd_data  <= hrdata;
      end
      if (d_cmp && dlast)               done <= 1'b1;
      if (e_hit && hready)              err  <= 1'b1;
      if (state == S_ERROR && hready)   err  <= 1'b1;
    end
  end

endmodule
